// File: rtl/mrv1_th_barrier.sv
`default_nettype none
// mrv1_th_barrier: per-core thread barrier controller issuing single-cycle release pulses.
// Optional per-barrier watchdog force-release is built when MRV1_BARRIER_TIMEOUT_EN is defined.
module mrv1_th_barrier #(
  parameter int NUM_THREADS_P   = 8,
  parameter int NUM_BARRIERS_P  = 8,
  parameter int TIMEOUT_P       = 1024,
  parameter int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  parameter int BAR_ID_WIDTH_LP = $clog2(NUM_BARRIERS_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       bar_vld_i,
  input  logic [TID_WIDTH_LP-1:0]    bar_tid_i,
  input  logic [BAR_ID_WIDTH_LP-1:0] bar_id_i,
  input  logic [TID_WIDTH_LP-1:0]    bar_size_m1_i,
  output logic [NUM_THREADS_P-1:0]   stall_mask_o,
  output logic                       rel_vld_o,
  output logic [BAR_ID_WIDTH_LP-1:0] rel_id_o,
  output logic [NUM_THREADS_P-1:0]   rel_mask_o,
  output logic                       rel_timeout_o,
  output logic                       err_o
);

  typedef enum logic {BAR_IDLE = 1'b0, BAR_ARMED = 1'b1} bar_state_e;

  bar_state_e                state       [NUM_BARRIERS_P];
  bar_state_e                state_nxt   [NUM_BARRIERS_P];
  logic [TID_WIDTH_LP-1:0]   size_m1     [NUM_BARRIERS_P];
  logic [TID_WIDTH_LP-1:0]   size_m1_nxt [NUM_BARRIERS_P];
  logic [TID_WIDTH_LP-1:0]   cnt         [NUM_BARRIERS_P];
  logic [TID_WIDTH_LP-1:0]   cnt_nxt     [NUM_BARRIERS_P];
  logic [NUM_THREADS_P-1:0]  mask        [NUM_BARRIERS_P];
  logic [NUM_THREADS_P-1:0]  mask_nxt    [NUM_BARRIERS_P];

  logic [NUM_THREADS_P-1:0]   tid_oh;
  logic [NUM_THREADS_P-1:0]   other_mask;
  logic [NUM_THREADS_P-1:0]   stall_nxt;
  logic [TID_WIDTH_LP-1:0]    cnt_inc;
  logic                       in_same;
  logic                       in_other;
  logic                       accepted;
  logic                       rel_vld_nxt;
  logic [BAR_ID_WIDTH_LP-1:0] rel_id_nxt;
  logic [NUM_THREADS_P-1:0]   rel_mask_nxt;
  logic                       err_nxt;

`ifdef MRV1_BARRIER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_P) + 1;
  // Expiry is flagged one count early so the registered release lands exactly TIMEOUT_P cycles after arming.
  localparam logic [WDOG_W-1:0] WDOG_EXP = WDOG_W'(TIMEOUT_P - 2);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_P - 1);

  logic [WDOG_W-1:0]         wdog     [NUM_BARRIERS_P];
  logic [WDOG_W-1:0]         wdog_nxt [NUM_BARRIERS_P];
  logic [NUM_BARRIERS_P-1:0] expired;
  logic                      t_found;
  logic [BAR_ID_WIDTH_LP-1:0] t_sel;
  logic                      rel_timeout_nxt;
`endif

  assign tid_oh = {{(NUM_THREADS_P-1){1'b0}}, 1'b1} << bar_tid_i;

  always_comb begin
    for (int b = 0; b < NUM_BARRIERS_P; b++) begin
      state_nxt[b]   = state[b];
      size_m1_nxt[b] = size_m1[b];
      cnt_nxt[b]     = cnt[b];
      mask_nxt[b]    = mask[b];
    end
    rel_vld_nxt  = 1'b0;
    rel_id_nxt   = '0;
    rel_mask_nxt = '0;
    err_nxt      = 1'b0;
    accepted     = 1'b0;
    other_mask   = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) begin
      if (BAR_ID_WIDTH_LP'(b) != bar_id_i) other_mask = other_mask | mask[b];
    end
    in_same  = |(mask[bar_id_i] & tid_oh);
    in_other = |(other_mask & tid_oh);
    cnt_inc  = cnt[bar_id_i] + 1'b1;

    if (bar_vld_i) begin
      if (in_other || in_same) begin
        err_nxt = 1'b1;
      end else if (state[bar_id_i] == BAR_IDLE) begin
        accepted = 1'b1;
        if (bar_size_m1_i == '0) begin
          rel_vld_nxt  = 1'b1;
          rel_id_nxt   = bar_id_i;
          rel_mask_nxt = tid_oh;
        end else begin
          state_nxt[bar_id_i]   = BAR_ARMED;
          size_m1_nxt[bar_id_i] = bar_size_m1_i;
          cnt_nxt[bar_id_i]     = '0;
          mask_nxt[bar_id_i]    = tid_oh;
        end
      end else begin
        accepted = 1'b1;
        // A size disagreement is flagged but the arrival still counts against the latched size.
        if (bar_size_m1_i != size_m1[bar_id_i]) err_nxt = 1'b1;
        if (cnt_inc == size_m1[bar_id_i]) begin
          rel_vld_nxt         = 1'b1;
          rel_id_nxt          = bar_id_i;
          rel_mask_nxt        = mask[bar_id_i] | tid_oh;
          state_nxt[bar_id_i] = BAR_IDLE;
          cnt_nxt[bar_id_i]   = '0;
          mask_nxt[bar_id_i]  = '0;
        end else begin
          cnt_nxt[bar_id_i]  = cnt_inc;
          mask_nxt[bar_id_i] = mask[bar_id_i] | tid_oh;
        end
      end
    end

`ifdef MRV1_BARRIER_TIMEOUT_EN
    rel_timeout_nxt = 1'b0;
    t_found         = 1'b0;
    t_sel           = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) begin
      wdog_nxt[b] = (state[b] == BAR_ARMED && wdog[b] != WDOG_MAX) ? wdog[b] + 1'b1 : wdog[b];
      expired[b]  = (state[b] == BAR_ARMED) && (wdog[b] >= WDOG_EXP) &&
                    !(accepted && BAR_ID_WIDTH_LP'(b) == bar_id_i);
    end
    if (accepted) wdog_nxt[bar_id_i] = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) begin
      if (expired[b] && !t_found) begin
        t_found = 1'b1;
        t_sel   = BAR_ID_WIDTH_LP'(b);
      end
    end
    // A natural release owns the output this cycle; a pending timeout simply waits.
    if (t_found && !rel_vld_nxt) begin
      rel_vld_nxt      = 1'b1;
      rel_timeout_nxt  = 1'b1;
      rel_id_nxt       = t_sel;
      rel_mask_nxt     = mask[t_sel];
      state_nxt[t_sel] = BAR_IDLE;
      cnt_nxt[t_sel]   = '0;
      mask_nxt[t_sel]  = '0;
      wdog_nxt[t_sel]  = '0;
    end
`endif

    stall_nxt = '0;
    for (int b = 0; b < NUM_BARRIERS_P; b++) stall_nxt = stall_nxt | mask_nxt[b];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
        state[b]   <= BAR_IDLE;
        size_m1[b] <= '0;
        cnt[b]     <= '0;
        mask[b]    <= '0;
      end
      stall_mask_o <= '0;
      rel_vld_o    <= 1'b0;
      rel_id_o     <= '0;
      rel_mask_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
        state[b]   <= state_nxt[b];
        size_m1[b] <= size_m1_nxt[b];
        cnt[b]     <= cnt_nxt[b];
        mask[b]    <= mask_nxt[b];
      end
      stall_mask_o <= stall_nxt;
      rel_vld_o    <= rel_vld_nxt;
      rel_id_o     <= rel_id_nxt;
      rel_mask_o   <= rel_mask_nxt;
      err_o        <= err_nxt;
    end
  end

`ifdef MRV1_BARRIER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) wdog[b] <= '0;
      rel_timeout_o <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) wdog[b] <= wdog_nxt[b];
      rel_timeout_o <= rel_timeout_nxt;
    end
  end
`else
  assign rel_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/mrv1_th_barrier.md
# mrv1_th_barrier

Per-core thread barrier controller for the IMT pipeline. Accepts barrier-arrival commands from the thread-control path. For each barrier ID it tracks which threads are waiting and how many have arrived. When the expected count is reached it emits a single-cycle release carrying the mask of threads to wake. It sits beside the thread scheduler: `stall_mask_o` gates thread readiness, and `rel_mask_o` tells the scheduler which stalled threads to clear.

## Interface
- `NUM_THREADS_P`, 8, hardware threads per core
- `NUM_BARRIERS_P`, 8, independent barrier IDs
- `TIMEOUT_P`, 1024, watchdog limit in cycles; used only with `MRV1_BARRIER_TIMEOUT_EN`
- `TID_WIDTH_LP`, $clog2(NUM_THREADS_P), thread-ID width
- `BAR_ID_WIDTH_LP`, $clog2(NUM_BARRIERS_P), barrier-ID width

Ports:
- `clk_i`  in  1  clock; single clock domain
- `rst_i`  in  1  synchronous reset, active-high
- `flush_i`  in  1  drop all barrier state; has the same effect as reset on state
- `bar_vld_i`  in  1  arrival command valid; at most one per cycle
- `bar_tid_i`  in  TID_WIDTH_LP  arriving thread
- `bar_id_i`  in  BAR_ID_WIDTH_LP  target barrier
- `bar_size_m1_i`  in  TID_WIDTH_LP  participant count minus one
- `stall_mask_o`  out  NUM_THREADS_P  threads currently waiting on any barrier
- `rel_vld_o`  out  1  release pulse
- `rel_id_o`  out  BAR_ID_WIDTH_LP  released barrier
- `rel_mask_o`  out  NUM_THREADS_P  threads released
- `rel_timeout_o`  out  1  release was forced by the watchdog
- `err_o`  out  1  protocol-error pulse

## Operation
Each barrier b holds:
- state: IDLE or ARMED
- `size_m1[b]`
- `cnt[b]`, width TID_WIDTH_LP
- `mask[b]`, NUM_THREADS_P bits
- `wdog[b]`, only with the macro

Arrival handling, when `bar_vld_i` is high:
- **Barrier IDLE, `bar_size_m1_i`==0:**
  - release next cycle with `rel_mask_o`=onehot(tid).
  - barrier stays IDLE.
  - the thread is never shown in `stall_mask_o`.
- **Barrier IDLE, `bar_size_m1_i`>0:**
  - state→ARMED, `size_m1`←`bar_size_m1_i`, `cnt`←0, `mask`←onehot(tid).
- **Barrier ARMED, tid already in `mask[b]`:**
  - arrival ignored; `err_o` pulses next cycle.
- **Barrier ARMED, `bar_size_m1_i`≠`size_m1[b]`:**
  - `err_o` pulses next cycle.
  - arrival still counted, against the latched `size_m1`.
- **Barrier ARMED, otherwise:**
  - `mask`|=onehot(tid).
  - if `cnt+1`==`size_m1`: release `mask|onehot(tid)` next cycle, state→IDLE, `cnt`←0, `mask`←0.
  - else `cnt`←`cnt+1`.
- **tid already waiting in a different barrier:**
  - `err_o` pulses next cycle; arrival ignored.

Other rules:
- `stall_mask_o` = OR over b of `mask[b]`, registered.
- Because there is one arrival per cycle, there is at most one natural release per cycle, so no arbitration is needed for natural releases.
- Releases happen in arrival order.

## Timing
- Reset values: `stall_mask_o`=0, `rel_vld_o`=0, `rel_id_o`=0, `rel_mask_o`=0, `rel_timeout_o`=0, `err_o`=0. All barriers IDLE with zeroed counters.
- Arrival at cycle N:
  - thread bit appears in `stall_mask_o` at N+1 (non-releasing arrivals only).
  - the releasing arrival produces `rel_vld_o` at N+1.
  - on a release, `stall_mask_o` drops the released bits at N+1, the same cycle as `rel_vld_o`.
- `rel_vld_o` and `err_o` are single-cycle pulses, registered. There is no backpressure: the scheduler must accept every release.
- `flush_i` at cycle N:
  - all barriers IDLE and masks cleared at N+1.
  - no release is emitted.
  - an arrival in cycle N is discarded.
  - flush takes priority over arrival.
- A barrier can be re-armed by an arrival in the cycle right after its release.

## Configuration
`MRV1_BARRIER_TIMEOUT_EN`:
- **Defined:**
  - each ARMED barrier runs `wdog`, cleared on arm and on every accepted arrival, incremented every cycle while ARMED.
  - when `wdog` reaches `TIMEOUT_P-1`, the barrier force-releases its current mask with `rel_timeout_o`=1 and goes IDLE.
  - if a natural release and a timeout coincide, the natural release goes first; the timed-out barrier holds and releases on the next cycle.
  - multiple simultaneous timeouts are serviced lowest ID first, one per cycle.
- **Undefined:**
  - no watchdog logic is built.
  - `rel_timeout_o` is tied to 0 and `TIMEOUT_P` is ignored.

## Test plan
- Size 3 on barrier 2, arrivals tid 0,1,2,3 on consecutive cycles → `stall_mask_o` goes 0x01, 0x03, 0x07. The cycle after tid 3 arrives: `rel_vld_o`=1, `rel_id_o`=2, `rel_mask_o`=0x0F, `stall_mask_o`=0x00.
- `bar_size_m1_i`=0, tid 5 → `rel_mask_o`=0x20 next cycle; `stall_mask_o` never nonzero.
- Barrier 1 armed with tid 4, then tid 4 arrives again → `err_o` pulse; `stall_mask_o` stays 0x10; no release.
- Barriers 0 and 3 interleaved: tids 0 and 1 on barrier 0 (size_m1=1), tid 2 on barrier 3 (size_m1=1) → barrier 0 releases 0x03 while 0x04 stays stalled. Then tid 6 on barrier 3 → release 0x44.
- Barrier 0 armed with 0x03, then `flush_i` asserted together with an arrival → all outputs 0 next cycle; no `rel_vld_o`.
- With `MRV1_BARRIER_TIMEOUT_EN` and `TIMEOUT_P`=16: arm barrier 7 with tid 1 and send nothing further → exactly 16 cycles after the arrival, `rel_vld_o`=1, `rel_mask_o`=0x02, `rel_timeout_o`=1.
